acc_control_unit: RTL and testbench

- Instruction-sequencing FSM for the 8-bit microprocessor.
- Fetches an 8-bit instruction, decodes it, and drives the control strobes consumed by the accumulator, ALU, register file and program counter: SelAcc, LoadAcc, alu_op, reg_we and the PC controls.
- It is the producer end of the accumulator's load/select interface.
- It sits between instruction memory/PC and the datapath.

---
 rtl/acc_control_unit_pkg.sv | 58 +++++
 rtl/acc_control_unit_decoder.sv | 43 ++++
 rtl/acc_control_unit.sv | 115 +++++++++++
 tb/tb_acc_control_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/acc_control_unit_pkg.sv
// Shared types and encodings for the accumulator machine's
// instruction sequencer and its opcode decoder.
package acc_control_unit_pkg;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXECUTE,
    HALT
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] SEL_IMM = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;

  typedef enum logic [1:0] {
    JC_ALWAYS,
    JC_ZERO,
    JC_CARRY
  } jcond_e;

  typedef struct packed {
    logic [1:0] sel;
    logic       load_acc;
    logic       reg_we;
    logic [3:0] alu_op;
    logic       is_jump;
    jcond_e     cond;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/acc_control_unit_decoder.sv
// Pure combinational opcode decoder: produces the intents that the
// sequencer later qualifies with state and flags.
module acc_instr_decoder
  import acc_control_unit_pkg::*;
(
  input  logic [3:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o      = '0;
    dec_o.cond = JC_ALWAYS;
    unique case (op_i)
      OP_LDI: begin
        dec_o.sel      = SEL_IMM;
        dec_o.load_acc = 1'b1;
      end
      OP_LDR: begin
        dec_o.sel      = SEL_REG;
        dec_o.load_acc = 1'b1;
      end
      OP_STR: dec_o.reg_we = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        dec_o.sel      = SEL_ALU;
        dec_o.load_acc = 1'b1;
        dec_o.alu_op   = op_i - OP_ADD;
      end
      OP_JMP: dec_o.is_jump = 1'b1;
      OP_JZ: begin
        dec_o.is_jump = 1'b1;
        dec_o.cond    = JC_ZERO;
      end
      OP_JC: begin
        dec_o.is_jump = 1'b1;
        dec_o.cond    = JC_CARRY;
      end
      OP_HLT: dec_o.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_control_unit.sv
// Three-cycle fetch/decode/execute sequencer driving the accumulator,
// ALU, register file and PC strobes; HALT holds until reset.
module acc_control_unit
  import acc_control_unit_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      instr,
  input  logic            zero_flag,
  input  logic            carry_flag,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [PC_W-1:0] jump_addr,
  output logic [3:0]      Imm,
  output logic [3:0]      reg_addr,
  output logic            reg_we,
  output logic [1:0]      SelAcc,
  output logic            LoadAcc,
  output logic [3:0]      alu_op,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [7:0]      ir_q;
  logic [OP_W-1:0] opcode;
  dec_t            dec;
  logic            take;

  assign opcode = ir_q[7 -: OP_W];

  acc_instr_decoder u_dec (
    .op_i  (opcode),
    .dec_o (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) ir_q <= instr;
    end
  end

  always_comb begin
    take = 1'b0;
    unique case (dec.cond)
      JC_ALWAYS: take = dec.is_jump;
      JC_ZERO:   take = dec.is_jump & zero_flag;
      JC_CARRY:  take = dec.is_jump & carry_flag;
      default:   take = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    reg_we    = 1'b0;
    LoadAcc   = 1'b0;
    SelAcc    = SEL_IMM;
    alu_op    = ALU_ADD;
    halted    = 1'b0;
    Imm       = ir_q[3:0];
    reg_addr  = ir_q[3:0];
    jump_addr = {{(PC_W-4){1'b0}}, ir_q[3:0]};
    unique case (state_q)
      FETCH: begin
        ir_load = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        SelAcc  = dec.sel;
        alu_op  = dec.alu_op;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        SelAcc  = dec.sel;
        alu_op  = dec.alu_op;
        LoadAcc = dec.load_acc;
        reg_we  = dec.reg_we;
        if (dec.is_halt) begin
          state_d = HALT;
        end else begin
          pc_load = take;
          pc_inc  = ~take;
          state_d = FETCH;
        end
      end
      HALT: halted = 1'b1;
      default: state_d = FETCH;
    endcase
    // Reset silences every output, including the IR-derived fields.
    if (rst) begin
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      reg_we    = 1'b0;
      LoadAcc   = 1'b0;
      SelAcc    = SEL_IMM;
      alu_op    = ALU_ADD;
      halted    = 1'b0;
      Imm       = 4'h0;
      reg_addr  = 4'h0;
      jump_addr = '0;
    end
  end

endmodule

// File: tb/tb_acc_control_unit.sv
// Directed plus random stimulus checked against a cycle-level
// reference model of the instruction sequencer.
module tb_acc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       zero_flag;
  logic       carry_flag;
  logic       ir_load, pc_inc, pc_load, reg_we, LoadAcc, halted;
  logic [7:0] jump_addr;
  logic [3:0] Imm, reg_addr, alu_op;
  logic [1:0] SelAcc;

  int checks = 0;
  int errors = 0;

  // model: phase 0 fetch, 1 decode, 2 execute, 3 halted
  int         m_phase = 0;
  logic [7:0] m_ir = 8'h00;
  int         loadacc_seen = 0;

  always #5 clk = ~clk;

  acc_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .jump_addr  (jump_addr),
    .Imm        (Imm),
    .reg_addr   (reg_addr),
    .reg_we     (reg_we),
    .SelAcc     (SelAcc),
    .LoadAcc    (LoadAcc),
    .alu_op     (alu_op),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] in,
                      input logic z, input logic c);
    int op, lo;
    logic alu_grp, ex, dx, taken;
    logic [7:0] e_sel, e_alu;
    rst = r; instr = in; zero_flag = z; carry_flag = c;
    @(negedge clk);
    op      = int'(m_ir[7:4]);
    lo      = int'(m_ir[3:0]);
    alu_grp = (op >= 4) && (op <= 11);
    ex      = !r && m_phase == 2;
    dx      = !r && (m_phase == 1 || m_phase == 2);
    taken   = op == 12 || (op == 13 && z) || (op == 14 && c);
    e_sel   = !dx ? 8'd0 : op == 2 ? 8'd1 : alu_grp ? 8'd2 : 8'd0;
    e_alu   = (dx && alu_grp) ? 8'(op - 4) : 8'd0;
    chk("ir_load", 8'(ir_load), 8'(!r && m_phase == 0));
    chk("pc_inc", 8'(pc_inc), 8'(ex && !taken && op != 15));
    chk("pc_load", 8'(pc_load), 8'(ex && taken));
    chk("reg_we", 8'(reg_we), 8'(ex && op == 3));
    chk("LoadAcc", 8'(LoadAcc),
        8'(ex && (op == 1 || op == 2 || alu_grp)));
    chk("SelAcc", 8'(SelAcc), e_sel);
    chk("alu_op", 8'(alu_op), e_alu);
    chk("halted", 8'(halted), 8'(!r && m_phase == 3));
    chk("Imm", 8'(Imm), r ? 8'd0 : 8'(lo));
    chk("reg_addr", 8'(reg_addr), r ? 8'd0 : 8'(lo));
    chk("jump_addr", jump_addr, r ? 8'd0 : 8'(lo));
    if (LoadAcc) loadacc_seen++;
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_ir    = 8'h00;
    end else begin
      case (m_phase)
        0: begin m_ir = in; m_phase = 1; end
        1: m_phase = 2;
        2: m_phase = (op == 15) ? 3 : 0;
        default: m_phase = 3;
      endcase
    end
    #1;
  endtask

  task automatic run_instr(input logic [7:0] in, input logic z,
                           input logic c);
    step(1'b0, in, z, c);
    step(1'b0, 8'($urandom), ~z, ~c);
    step(1'b0, 8'($urandom), z, c);
  endtask

  initial begin
    rst = 1'b1; instr = 8'h00; zero_flag = 1'b0; carry_flag = 1'b0;
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    run_instr(8'h15, 1'b0, 1'b0);
    run_instr(8'h4A, 1'b0, 1'b0);
    run_instr(8'hB3, 1'b1, 1'b1);
    run_instr(8'hD9, 1'b1, 1'b0);
    run_instr(8'hD9, 1'b0, 1'b1);
    run_instr(8'hE3, 1'b0, 1'b1);
    run_instr(8'hE3, 1'b1, 1'b0);
    run_instr(8'h37, 1'b0, 1'b0);
    run_instr(8'hC5, 1'b0, 1'b0);
    run_instr(8'h00, 1'b1, 1'b1);
    run_instr(8'h2C, 1'b0, 1'b0);
    run_instr(8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    step(1'b1, 8'h15, 1'b0, 1'b0);
    run_instr(8'h15, 1'b0, 1'b0);
    // reset during DECODE of an LDR must never produce a load
    loadacc_seen = 0;
    step(1'b0, 8'h2A, 1'b0, 1'b0);
    step(1'b1, 8'h2A, 1'b1, 1'b1);
    step(1'b1, 8'h2A, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ldr_abandoned", 8'(loadacc_seen), 8'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = (m_phase == 3) ? ($urandom_range(0, 4) == 0)
                         : ($urandom_range(0, 39) == 0);
      step(r, 8'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
